// File: rtl/dpsram_rd_streamer.sv
// Read-side streamer for a dpsram port: turns an (addr, len) command into back-to-back SRAM reads
// and a valid/ready word stream with a last flag. Optional stall counter: DPSRAM_RD_STREAMER_PERF_EN.
module dpsram_rd_streamer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 1024,
  parameter  int BYTE_SIZE  = 32,
  parameter  int LEN_W      = 8,
  localparam int AW         = $clog2(DATA_DEPTH),
  localparam int WE_W       = DATA_WIDTH / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [AW-1:0]         cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  output logic                  sram_en_o,
  output logic [WE_W-1:0]       sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_last_o,
  output logic                  busy_o
`ifdef DPSRAM_RD_STREAMER_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and data/last hold steady while valid waits for ready.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AW-1:0]           r_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_inflight;
  logic                    r_inflight_last;
  logic [DATA_WIDTH-1:0]   r_fifo_data [2];
  logic [1:0]              r_fifo_last;
  logic                    r_rd_ptr;
  logic                    r_wr_ptr;
  logic [1:0]              r_cnt;

  logic                    w_cmd_hs;
  logic                    w_cmd_start;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_issue;
  logic                    w_last_issue;
  logic                    w_drain_done;
  logic [2:0]              w_used;
  logic [AW-1:0]           w_addr_inc;

  assign w_cmd_hs     = cmd_valid_i && (r_state == S_IDLE);
  assign w_cmd_start  = w_cmd_hs && (cmd_len_i != '0);
  assign w_pop        = data_valid_o && data_ready_i;
  assign w_push       = r_inflight;

  // Credits: words already buffered plus the read in flight, less the one leaving this cycle.
  assign w_used       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_RUN) && (w_used < 3'd2);
  assign w_last_issue = w_issue && (r_remaining == LEN_W'(1));

  // Leave DRAIN as soon as the final word is leaving, so busy drops right after it.
  assign w_drain_done = !r_inflight && (r_cnt == {1'b0, w_pop});

  assign w_addr_inc   = (r_addr == AW'(DATA_DEPTH - 1)) ? '0 : r_addr + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
      r_fifo_last     <= '0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cmd_start) begin
        r_addr      <= cmd_addr_i;
        r_remaining <= cmd_len_i;
      end else if (w_issue) begin
        r_addr      <= w_addr_inc;
        r_remaining <= r_remaining - LEN_W'(1);
      end

      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= sram_rdata_i;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign sram_en_o    = w_issue;
  assign sram_we_o    = '0;
  assign sram_addr_o  = r_addr;
  assign data_valid_o = (r_cnt != '0);
  assign data_o       = r_fifo_data[r_rd_ptr];
  assign data_last_o  = r_fifo_last[r_rd_ptr];

`ifdef DPSRAM_RD_STREAMER_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (data_valid_o && !data_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dpsram_rd_streamer.sv
// Bench for dpsram_rd_streamer: SRAM model, command driver, ready driver, scoreboard monitor,
// a table of burst vectors and hand-written corner-case sequences.
module tb_dpsram_rd_streamer;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int WEW   = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [AW-1:0]   cmd_addr_i  = '0;
  logic [LW-1:0]   cmd_len_i   = '0;
  logic            sram_en_o;
  logic [WEW-1:0]  sram_we_o;
  logic [AW-1:0]   sram_addr_o;
  logic [DW-1:0]   sram_rdata_i = '0;
  logic            data_valid_o;
  logic            data_ready_i = 1'b1;
  logic [DW-1:0]   data_o;
  logic            data_last_o;
  logic            busy_o;
`ifdef DPSRAM_RD_STREAMER_PERF_EN
  logic [31:0]     stall_cnt_o;
`endif

  dpsram_rd_streamer #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(32), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_o(data_o), .data_last_o(data_last_o), .busy_o(busy_o)
`ifdef DPSRAM_RD_STREAMER_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  // SRAM model: registered read, output holds when not enabled.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (sram_en_o) sram_rdata_i <= mem[sram_addr_o];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] last_issue_addr = '0;
  int            pop_count    = 0;
  int            stall_cycles = 0;
  int            outstanding  = 0;
  bit            stall_prev   = 1'b0;
  logic [DW-1:0] prev_data    = '0;
  logic          prev_last    = 1'b0;

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      automatic bit          pop = data_valid_o && data_ready_i;
      automatic logic [DW:0] e;
      if (sram_en_o) begin
        check("credit_limit", 64'((outstanding - int'(pop)) < 2), 64'd1);
        addr_log.push_back(sram_addr_o);
        last_issue_addr = sram_addr_o;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(data_valid_o), 64'd1);
        check("stall_data",  64'(data_o), 64'(prev_data));
        check("stall_last",  64'(data_last_o), 64'(prev_last));
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("data", 64'(data_o), 64'(e[DW-1:0]));
          check("last", 64'(data_last_o), 64'(e[DW]));
        end
        pop_count++;
      end
      if (data_valid_o && !data_ready_i) stall_cycles++;
      stall_prev  = data_valid_o && !data_ready_i;
      prev_data   = data_o;
      prev_last   = data_last_o;
      outstanding = outstanding + int'(sram_en_o) - int'(pop);
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;
  int rp = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      rp++;
      case (ready_mode)
        1:       data_ready_i = (rp % 3 == 0);
        2:       data_ready_i = 1'($urandom_range(0, 1));
        default: data_ready_i = 1'b1;
      endcase
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit keep_valid,
                          output int hs_cyc);
    int waited = 0;
    bit done   = 1'b0;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    cmd_valid_i = 1'b1;
    hs_cyc      = -1;
    while (!done) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        done = 1'b1;
        hs_cyc = cyc;
        check("hs_after_drain", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < int'(l); i++) begin
          automatic int idx = (int'(a) + i) % DEPTH;
          exp_q.push_back({(i == int'(l) - 1), mem[idx]});
        end
      end else if (++waited > 2000) begin
        check("cmd_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    bit done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0) done = 1'b1;
      else if (++waited > 3000) begin
        check("idle_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            mode;
    int            exp_words;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int hs;
    int first_en, first_v, last_c;
`ifdef DPSRAM_RD_STREAMER_PERF_EN
    logic [31:0] stall_before;
`endif

    vecs[0] = '{addr: 10'd16,   len: 8'd4,   mode: 0, exp_words: 4,   exp_last_addr: 10'd19};
    vecs[1] = '{addr: 10'd1022, len: 8'd4,   mode: 0, exp_words: 4,   exp_last_addr: 10'd1};
    vecs[2] = '{addr: 10'd200,  len: 8'd8,   mode: 1, exp_words: 8,   exp_last_addr: 10'd207};
    vecs[3] = '{addr: 10'd300,  len: 8'd8,   mode: 2, exp_words: 8,   exp_last_addr: 10'd307};
    vecs[4] = '{addr: 10'd5,    len: 8'd1,   mode: 0, exp_words: 1,   exp_last_addr: 10'd5};
    vecs[5] = '{addr: 10'd500,  len: 8'd255, mode: 2, exp_words: 255, exp_last_addr: 10'd754};
    vecs[6] = '{addr: 10'd1020, len: 8'd9,   mode: 1, exp_words: 9,   exp_last_addr: 10'd4};

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_sram_en",   64'(sram_en_o), 64'd0);
    check("rst_sram_we",   64'(sram_we_o), 64'd0);
    check("rst_sram_addr", 64'(sram_addr_o), 64'd0);
    check("rst_valid",     64'(data_valid_o), 64'd0);
    check("rst_data",      64'(data_o), 64'd0);
    check("rst_last",      64'(data_last_o), 64'd0);
    check("rst_busy",      64'(busy_o), 64'd0);
`ifdef DPSRAM_RD_STREAMER_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency / throughput / last / busy on a 4-word burst
    ready_mode = 0;
    pop_count  = 0;
    send_cmd(10'd16, 8'd4, 1'b0, hs);
    first_en = -1; first_v = -1; last_c = -1;
    for (int k = 0; k < 20 && last_c < 0; k++) begin
      @(negedge clk);
      if (sram_en_o && first_en < 0) first_en = cyc;
      if (data_valid_o && first_v < 0) first_v = cyc;
      if (data_valid_o && data_ready_i && data_last_o) last_c = cyc;
    end
    check("first_issue_lat", 64'(first_en - hs), 64'd1);
    check("first_valid_lat", 64'(first_v - hs), 64'd3);
    check("burst_span",      64'(last_c - first_v), 64'd3);
    @(negedge clk);
    check("busy_after_last", 64'(busy_o), 64'd0);
    check("burst_pops",      64'(pop_count), 64'd4);
    check("sram_we_const",   64'(sram_we_o), 64'd0);
    @(posedge clk); #1;

    // Table-driven bursts
    foreach (vecs[v]) begin
      ready_mode   = vecs[v].mode;
      addr_log.delete();
      pop_count    = 0;
      stall_cycles = 0;
`ifdef DPSRAM_RD_STREAMER_PERF_EN
      stall_before = stall_cnt_o;
`endif
      send_cmd(vecs[v].addr, vecs[v].len, 1'b0, hs);
      wait_idle();
      check("vec_words",     64'(pop_count), 64'(vecs[v].exp_words));
      check("vec_issues",    64'(addr_log.size()), 64'(vecs[v].exp_words));
      check("vec_last_addr", 64'(last_issue_addr), 64'(vecs[v].exp_last_addr));
`ifdef DPSRAM_RD_STREAMER_PERF_EN
      check("vec_stall_cnt", 64'(stall_cnt_o - stall_before), 64'(stall_cycles));
`endif
    end

    // Address wrap sequence
    ready_mode = 0;
    addr_log.delete();
    send_cmd(10'(DEPTH - 2), 8'd4, 1'b0, hs);
    wait_idle();
    check("wrap_count", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", 64'(addr_log[0]), 64'd1022);
      check("wrap_a1", 64'(addr_log[1]), 64'd1023);
      check("wrap_a2", 64'(addr_log[2]), 64'd0);
      check("wrap_a3", 64'(addr_log[3]), 64'd1);
    end

    // Zero-length command
    send_cmd(10'd50, 8'd0, 1'b0, hs);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("len0_ready", 64'(cmd_ready_o), 64'd1);
      check("len0_en",    64'(sram_en_o), 64'd0);
      check("len0_valid", 64'(data_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    pop_count = 0;
    send_cmd(10'd60, 8'd2, 1'b0, hs);
    wait_idle();
    check("after_len0_words", 64'(pop_count), 64'd2);

    // Reset in the middle of a burst
    send_cmd(10'd100, 8'd10, 1'b0, hs);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", 64'(cmd_ready_o), 64'd1);
    check("mid_rst_en",    64'(sram_en_o), 64'd0);
    check("mid_rst_addr",  64'(sram_addr_o), 64'd0);
    check("mid_rst_valid", 64'(data_valid_o), 64'd0);
    check("mid_rst_data",  64'(data_o), 64'd0);
    check("mid_rst_last",  64'(data_last_o), 64'd0);
    check("mid_rst_busy",  64'(busy_o), 64'd0);
`ifdef DPSRAM_RD_STREAMER_PERF_EN
    check("mid_rst_stall", 64'(stall_cnt_o), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    pop_count = 0;
    send_cmd(10'd200, 8'd1, 1'b0, hs);
    wait_idle();
    check("post_rst_words", 64'(pop_count), 64'd1);

    // Back-to-back commands with valid held high
    ready_mode = 2;
    pop_count  = 0;
    send_cmd(10'd300, 8'd3, 1'b1, hs);
    send_cmd(10'd400, 8'd2, 1'b0, hs);
    wait_idle();
    check("b2b_words", 64'(pop_count), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
